alu_arbiter: RTL
================

# alu_arbiter

Sequencer and two-port arbiter for the shared 8-bit ALU datapath (operand registers feeding the function units and the big result mux). Two requesters submit {opcode, A, B} over valid/ready. The block grants one requester at a time, round-robin, and registers the operands and mux select into the ALU. It captures the mux output one cycle later and returns the result, tagged with the requester ID, over a valid/ready response port.

## Interface
- WIDTH, 8, operand/result width
- OPW, 3, opcode (big-mux select) width
- NUM_OPS, 8, opcodes 0..NUM_OPS-1 are legal; others flag an error
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  OPW  opcode, equal to the big-mux input index (AND = 3)
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- alu_sel  out  OPW  big-mux select, registered
- alu_a, alu_b  out  WIDTH  ALU operands, registered
- alu_result  in  WIDTH  big-mux output, combinational from alu_sel/alu_a/alu_b
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the op
- rsp_data  out  WIDTH  captured result
- rsp_err  out  1  opcode was >= NUM_OPS; rsp_data forced to 0

## Operation
- FSM states are IDLE, EXEC and RESP.
- IDLE: reqN_ready = grantN, where grant comes from the round-robin arbiter over the current valids. On a handshake: latch op/a/b into alu_sel/alu_a/alu_b, record the ID, set the error flag if op >= NUM_OPS, update last_grant, and go to EXEC.
- EXEC: one cycle. Capture alu_result (0 if error) into rsp_data, drive rsp_valid=1, go to RESP.
- RESP: hold rsp_valid, rsp_id, rsp_data and rsp_err stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE.
- Both ready outputs are 0 outside IDLE. There is no request pipelining and at most one op is in flight.
- Round-robin arbitration:
  - If only one valid is high, that requester is granted.
  - If both are high, the requester other than last_grant wins.
  - last_grant resets to 1, so req0 wins the first tie.
- Operands pass through unmodified; the block performs no arithmetic. Width handling (carry, wrap) belongs to the ALU.
- alu_sel/alu_a/alu_b hold their last values until the next grant. The ALU output is ignored outside EXEC.

## Timing
- Reset values: state=IDLE, req0_ready=req1_ready=0 while rst is high, alu_sel=0, alu_a=alu_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, last_grant=1.
- Latency: handshake on edge T, then EXEC during cycle T+1, then rsp_valid high from T+2. The minimum issue interval is 3 cycles (rsp_ready held high).
- Ready is combinational from the valids and state. Valid must not depend on ready.
- A requester held valid while not granted keeps its request. With both valids high continuously, grants alternate 0,1,0,1.
- A new handshake may occur in the cycle after the response handshake, never the same cycle.
- A request whose valid drops before being granted is simply not serviced; no state changes.
- Reset mid-operation (EXEC or RESP): return to IDLE next edge, drop the in-flight op, deassert rsp_valid, restore last_grant=1.
- rsp_ready while rsp_valid=0 has no effect.

## Structure
- Shared package alu_pkg holds:
  - the opcode enum matching big-mux input indices (OP_AND=3, etc.) and NUM_OPS;
  - the FSM state enum {IDLE, EXEC, RESP}.
- Sub-module rr_arb2 is a 2-input round-robin arbiter. Inputs: valids and last_grant. Output: one-hot grant. Combinational, with last_grant kept as a register in the parent.
- The parent holds the FSM, the operand/select registers and the response register.

## Test plan
- Single request: req0 {op=3, A=8'hF0, B=8'h3C} with rsp_ready=1. Expect alu_sel=3, A/B at the ALU in the cycle after the handshake; rsp_valid 2 cycles after the handshake with rsp_id=0, rsp_data=8'h30, rsp_err=0.
- Tie after reset: both valid on the same cycle. Expect req0 granted first, then req1; responses with rsp_id 0 then 1. Under continuous contention over 6 ops, grants are 0,1,0,1,0,1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid. Expect rsp_data/rsp_id stable, both readies 0, no new grant; the response is accepted on the cycle rsp_ready rises.
- Illegal opcode with NUM_OPS=6, req1 op=7: expect rsp_err=1, rsp_data=0, rsp_id=1, and the FSM returns to IDLE normally.
- Reset in RESP with rsp_valid=1: assert rst one cycle. Expect rsp_valid=0 and state IDLE after the edge; on the next tie req0 is granted.
- Valid withdrawn: req1 valid for one cycle while the block is in EXEC, then low. Expect no req1 handshake and no response for req1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencer: opcode encoding (equal to the big-mux
// input index) and the sequencer FSM states.
package alu_pkg;

   localparam int WIDTH_DEF   = 8;
   localparam int OPW_DEF     = 3;
   localparam int NUM_OPS_DEF = 8;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_OR   = 3'd2,
      OP_AND  = 3'd3,
      OP_XOR  = 3'd4,
      OP_SHL  = 3'd5,
      OP_SHR  = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic logic op_is_illegal(input int op, input int num_ops);
      return op >= num_ops;
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester that did not win last
// time is granted. last_grant is held by the parent.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = valid;
      if (valid == 2'b11) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Sequencer for the shared ALU: grants one of two requesters, registers the
// operands/select into the ALU, captures the result and returns it tagged.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; ready may depend on valid, valid must never depend on ready.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int OPW     = OPW_DEF,
   parameter int NUM_OPS = NUM_OPS_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [OPW-1:0]   alu_sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output state_e           dbg_state
);

   state_e           state_q, state_d;
   logic [OPW-1:0]   sel_q, sel_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             id_q, id_d;
   logic             err_q, err_d;
   logic             last_grant_q, last_grant_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;

   logic [1:0]       grant;
   logic [1:0]       ready;
   logic [OPW-1:0]   op_in;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;

   rr_arb2 u_arb (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   assign ready      = (state_q == IDLE && !rst) ? grant : 2'b00;
   assign req0_ready = ready[0];
   assign req1_ready = ready[1];

   assign op_in = grant[1] ? req1_op : req0_op;
   assign a_in  = grant[1] ? req1_a  : req0_a;
   assign b_in  = grant[1] ? req1_b  : req0_b;

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      a_d          = a_q;
      b_d          = b_q;
      id_d         = id_q;
      err_d        = err_q;
      last_grant_d = last_grant_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      unique case (state_q)
         IDLE: begin
            if (|ready) begin
               sel_d        = op_in;
               a_d          = a_in;
               b_d          = b_in;
               id_d         = grant[1];
               err_d        = op_is_illegal(int'(op_in), NUM_OPS);
               last_grant_d = grant[1];
               state_d      = EXEC;
            end
         end
         EXEC: begin
            // The mux output is only trusted here, one cycle after the select settles.
            rsp_data_d  = err_q ? '0 : alu_result;
            rsp_id_d    = id_q;
            rsp_err_d   = err_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= 1'b0;
         err_q        <= 1'b0;
         last_grant_q <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         a_q          <= a_d;
         b_q          <= b_d;
         id_q         <= id_d;
         err_q        <= err_d;
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign alu_sel   = sel_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign dbg_state = state_q;

endmodule
